// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multicycle multiply/divide unit: state codes,
// default operand width and the operation tag carried to the FINISH state.
package mult_div_unit_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] MD_IDLE   = 2'd0;
    localparam logic [1:0] MD_MULT   = 2'd1;
    localparam logic [1:0] MD_DIV    = 2'd2;
    localparam logic [1:0] MD_FINISH = 2'd3;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } md_op_e;

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's-complement negation: gives |x| when negate is the sign
// bit, and applies the final quotient/remainder sign after a divide.
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? ({WIDTH{1'b0}} - value) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring) unit.
// One iteration per clock; results land in hi/lo with a one-cycle end pulse.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_end,
    output logic             div_end,
    output logic             div_zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]    state;
    logic [CW-1:0] count;
    md_op_e        op_kind;
    logic          start_mult_q;
    logic          start_div_q;

    logic signed [WIDTH-1:0] mcand;
    logic [2*WIDTH:0]        acc;
    logic [WIDTH-1:0]        divisor;
    logic [WIDTH-1:0]        quo;
    logic [WIDTH-1:0]        rem;
    logic                    neg_q;
    logic                    neg_r;

    logic mult_go;
    logic div_go;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;

    logic signed [WIDTH:0] booth_hi;
    logic signed [WIDTH:0] booth_mc;
    logic signed [WIDTH:0] booth_sum;
    logic [2*WIDTH:0]      booth_next;

    logic [WIDTH:0]   div_shift;
    logic             div_fits;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // A held start level never retriggers; a simultaneous multiply edge wins.
    assign mult_go = (state == MD_IDLE) && start_mult && !start_mult_q;
    assign div_go  = (state == MD_IDLE) && start_div && !start_div_q && !(start_mult && !start_mult_q);
    assign busy    = (state != MD_IDLE);

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .value  (op_a),
        .negate (op_a[WIDTH-1]),
        .result (abs_a)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .value  (op_b),
        .negate (op_b[WIDTH-1]),
        .result (abs_b)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .value  (quo),
        .negate (neg_q),
        .result (quo_fixed)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (rem),
        .negate (neg_r),
        .result (rem_fixed)
    );

    // Booth step: the add is done one bit wider so -2^(W-1) operands stay exact.
    always_comb begin
        booth_hi = $signed({acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]});
        booth_mc = $signed({mcand[WIDTH-1], mcand});
        case (acc[1:0])
            2'b01:   booth_sum = booth_hi + booth_mc;
            2'b10:   booth_sum = booth_hi - booth_mc;
            default: booth_sum = booth_hi;
        endcase
        booth_next = {booth_sum, acc[WIDTH:1]};
    end

    // Restoring step on magnitudes; the remainder always stays below the divisor.
    always_comb begin
        div_shift = {rem, quo[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, divisor});
        div_diff  = WIDTH'(div_shift - {1'b0, divisor});
        rem_next  = div_fits ? div_diff : div_shift[WIDTH-1:0];
        quo_next  = {quo[WIDTH-2:0], div_fits};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= MD_IDLE;
            count        <= '0;
            op_kind      <= OP_MULT;
            start_mult_q <= 1'b0;
            start_div_q  <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            mult_end     <= 1'b0;
            div_end      <= 1'b0;
            div_zero     <= 1'b0;
        end else begin
            start_mult_q <= start_mult;
            start_div_q  <= start_div;
            mult_end     <= 1'b0;
            div_end      <= 1'b0;
            div_zero     <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (mult_go) begin
                        state   <= MD_MULT;
                        count   <= '0;
                        op_kind <= OP_MULT;
                    end else if (div_go) begin
                        if (op_b == '0) begin
                            div_end  <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state   <= MD_DIV;
                            count   <= '0;
                            op_kind <= OP_DIV;
                        end
                    end
                end
                MD_MULT, MD_DIV: begin
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= MD_FINISH;
                    end
                end
                MD_FINISH: begin
                    state <= MD_IDLE;
                    if (op_kind == OP_DIV) begin
                        hi      <= rem_fixed;
                        lo      <= quo_fixed;
                        div_end <= 1'b1;
                    end else begin
                        hi       <= acc[2*WIDTH:WIDTH+1];
                        lo       <= acc[WIDTH:1];
                        mult_end <= 1'b1;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    // Datapath registers: loaded at the start edge, stepped while iterating.
    always_ff @(posedge clock) begin
        if (mult_go) begin
            mcand <= op_a;
            acc   <= {{WIDTH{1'b0}}, op_b, 1'b0};
        end else if (state == MD_MULT) begin
            acc <= booth_next;
        end

        if (div_go) begin
            divisor <= abs_b;
            quo     <= abs_a;
            rem     <= '0;
            neg_q   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_r   <= op_a[WIDTH-1];
        end else if (state == MD_DIV) begin
            rem <= rem_next;
            quo <= quo_next;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases with literal results
// plus randomized operations compared every cycle against a timeline model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start_mult;
    logic         start_div;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         mult_end;
    logic         div_end;
    logic         div_zero;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi         (hi),
        .lo         (lo),
        .mult_end   (mult_end),
        .div_end    (div_end),
        .div_zero   (div_zero),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference arithmetic: exact 64-bit product, truncating signed divide.
    task automatic model_result(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] rh, output logic [W-1:0] rl);
        longint la, lb, p, q, r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (!is_div) begin
            p  = la * lb;
            rh = p[63:32];
            rl = p[31:0];
        end else begin
            q  = la / lb;
            r  = la % lb;
            rh = r[31:0];
            rl = q[31:0];
        end
    endtask

    bit           armed = 1'b0;
    bit           m_prev_mult, m_prev_div, m_is_div;
    int           m_timer;
    logic [W-1:0] m_pend_hi, m_pend_lo;
    logic [W-1:0] e_hi, e_lo;
    bit           e_mult_end, e_div_end, e_div_zero, e_busy;

    // Model: an accepted start makes the unit busy for W+1 edges, then results appear.
    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                m_prev_mult = 0; m_prev_div = 0; m_timer = 0; m_is_div = 0;
                e_hi = '0; e_lo = '0;
                e_mult_end = 0; e_div_end = 0; e_div_zero = 0;
                armed = 1'b1;
            end else begin
                e_mult_end = 0; e_div_end = 0; e_div_zero = 0;
                if (m_timer > 0) begin
                    m_timer--;
                    if (m_timer == 0) begin
                        e_hi = m_pend_hi;
                        e_lo = m_pend_lo;
                        if (m_is_div) e_div_end = 1;
                        else          e_mult_end = 1;
                    end
                end else if (start_mult && !m_prev_mult) begin
                    model_result(0, op_a, op_b, m_pend_hi, m_pend_lo);
                    m_is_div = 0;
                    m_timer  = W + 1;
                end else if (start_div && !m_prev_div) begin
                    if (op_b == '0) begin
                        e_div_end  = 1;
                        e_div_zero = 1;
                    end else begin
                        model_result(1, op_a, op_b, m_pend_hi, m_pend_lo);
                        m_is_div = 1;
                        m_timer  = W + 1;
                    end
                end
                m_prev_mult = start_mult;
                m_prev_div  = start_div;
            end
            e_busy = (m_timer != 0);
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (armed) begin
                chk("cyc_hi", hi, e_hi);
                chk("cyc_lo", lo, e_lo);
                chk("cyc_mult_end", W'(mult_end), W'(e_mult_end));
                chk("cyc_div_end", W'(div_end), W'(e_div_end));
                chk("cyc_div_zero", W'(div_zero), W'(e_div_zero));
                chk("cyc_busy", W'(busy), W'(e_busy));
            end
        end
    end

    // Raise a start, wait for its end pulse, then drop the start like the control FSM.
    task automatic run_op(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit lit, input int exp_edge,
                          input logic [W-1:0] xh, input logic [W-1:0] xl, input string name);
        int got;
        got  = -1;
        op_a = a;
        op_b = b;
        if (is_div) start_div = 1'b1;
        else        start_mult = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (mult_end || div_end) begin
                got = k;
                break;
            end
            op_a = $urandom;
            op_b = $urandom;
        end
        if (got < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_end required=end_pulse", name);
        end else if (lit) begin
            chk({name, "_edge"}, W'(got), W'(exp_edge));
            chk({name, "_hi"}, hi, xh);
            chk({name, "_lo"}, lo, xl);
            chk({name, "_model_hi"}, e_hi, xh);
            chk({name, "_model_lo"}, e_lo, xl);
            chk({name, "_kind"}, W'({mult_end, div_end}), is_div ? W'(1) : W'(2));
            chk({name, "_zero"}, W'(div_zero), W'(is_div && b == '0));
        end
        start_mult = 1'b0;
        start_div  = 1'b0;
        @(negedge clock);
    endtask

    function automatic logic [W-1:0] pick_operand(input bit allow_zero);
        case ($urandom_range(0, 9))
            0: return allow_zero ? '0 : 32'd3;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    int n_mult, n_div;

    initial begin
        reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clock);
        chk("reset_hi", hi, '0);
        chk("reset_lo", lo, '0);
        chk("reset_busy", W'(busy), '0);
        reset = 1'b0;
        @(negedge clock);

        run_op(0, 32'd7, 32'hFFFF_FFFD, 1, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_7_m3");
        run_op(0, 32'h8000_0000, 32'h8000_0000, 1, 33, 32'h4000_0000, 32'h0, "mult_min_min");
        run_op(1, 32'hFFFF_FFF9, 32'd2, 1, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 33, 32'h0, 32'h8000_0000, "div_min_m1");
        run_op(1, 32'd5, 32'd0, 1, 0, 32'h0, 32'h8000_0000, "div_by_zero");

        // Held start for 40 cycles must yield exactly one multiply.
        n_mult = 0; n_div = 0;
        op_a = 32'd12345; op_b = 32'hFFFF_0001; start_mult = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if (mult_end) n_mult++;
        end
        start_mult = 1'b0;
        @(negedge clock);
        chk("held_start_count", W'(n_mult), W'(1));

        // Both starts rising together: multiply only.
        n_mult = 0; n_div = 0;
        op_a = 32'd100; op_b = 32'd9; start_mult = 1'b1; start_div = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if (mult_end) n_mult++;
            if (div_end)  n_div++;
        end
        start_mult = 1'b0; start_div = 1'b0;
        @(negedge clock);
        chk("both_rise_mult", W'(n_mult), W'(1));
        chk("both_rise_div", W'(n_div), W'(0));
        chk("both_rise_lo", lo, 32'd900);

        // Reset at edge 10 of a divide aborts it.
        op_a = 32'd100; op_b = 32'd7; start_div = 1'b1;
        repeat (10) @(negedge clock);
        reset = 1'b1; start_div = 1'b0;
        @(negedge clock);
        chk("abort_busy", W'(busy), '0);
        chk("abort_hi", hi, '0);
        chk("abort_lo", lo, '0);
        chk("abort_end", W'({mult_end, div_end}), '0);
        reset = 1'b0;
        @(negedge clock);
        run_op(1, 32'd100, 32'd7, 1, 33, 32'd2, 32'd14, "div_after_abort");

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            bit           rdiv;
            rdiv = bit'($urandom_range(0, 1));
            ra   = pick_operand(1);
            rb   = pick_operand(rdiv);
            run_op(rdiv, ra, rb, 0, 0, '0, '0, "random");
        end

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
